// File: rtl/axis_forward_pkg.sv
// Shared types, frame geometry and Q8.8 helpers for the axis_forward block.
package axis_forward_pkg;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_SEND    = 2'd2
   } state_t;

   localparam int IN_BEATS       = 19;
   localparam int OUT_BEATS      = 4;
   localparam int FRAC_BITS      = 8;
   localparam int ACC_W          = 40;
   localparam int N_WORDS        = 76;
   localparam int N_MACS         = 9;
   localparam int VEC_LEN        = 9;

   // COMPUTE schedule: cycles 0..8 encoder MACs, 9 bias/saturate, 10..11 decoder MACs.
   localparam int CYC_BIAS       = 9;
   localparam int CYC_DEC1       = 10;
   localparam int CYC_DEC2       = 11;
   localparam int COMPUTE_CYCLES = 12;

   // Word offsets inside the parameter file.
   localparam int OFS_X   = 0;
   localparam int OFS_WC1 = 9;   // wc1, wd1, wc2, wd2 follow back to back, 9 words each
   localparam int OFS_B2  = 45;
   localparam int OFS_W   = 49;  // interleaved w11, w12, w21, w22, ...
   localparam int OFS_B3  = 67;

   localparam logic signed [ACC_W-1:0] SAT_HI = 40'sd32767;
   localparam logic signed [ACC_W-1:0] SAT_LO = -40'sd32768;

   // Clamp a wide signed value into the signed 16-bit Q8.8 range.
   function automatic logic signed [15:0] sat_q88(input logic signed [ACC_W-1:0] v);
      if (v > SAT_HI) begin
         return 16'sh7fff;
      end else if (v < SAT_LO) begin
         return 16'sh8000;
      end else begin
         return v[15:0];
      end
   endfunction

endpackage

// File: rtl/q88_mac.sv
// Signed 16x16 multiply-accumulate into a 40-bit accumulator. The output is
// the floor-shifted, bias-added, saturated value of the accumulator as it will
// stand after this cycle, so a result is usable in the same cycle as its last MAC.
module q88_mac
   import axis_forward_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_en,
   input  logic               i_clr,
   input  logic signed [15:0] i_a,
   input  logic signed [15:0] i_b,
   input  logic signed [15:0] i_bias,
   output logic signed [15:0] o_q
);

   logic signed [31:0]      w_prod;
   logic signed [ACC_W-1:0] w_acc_base;
   logic signed [ACC_W-1:0] w_acc_nxt;
   logic signed [ACC_W-1:0] w_shifted;
   logic signed [ACC_W-1:0] r_acc;

   assign w_prod     = i_a * i_b;
   assign w_acc_base = i_clr ? '0 : r_acc;
   assign w_acc_nxt  = i_en ? (w_acc_base + ACC_W'(w_prod)) : w_acc_base;
   assign w_shifted  = w_acc_nxt >>> FRAC_BITS;
   assign o_q        = sat_q88(w_shifted + ACC_W'(i_bias));

   // Accumulator update; every dot product starts with i_clr so no reset is needed.
   // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge i_clk) begin
      r_acc <= w_acc_nxt;
   end

endmodule

// File: rtl/axis_forward.sv
// Loads a 76-word Q8.8 parameter frame over AXI-Stream, runs a small
// deterministic encoder/decoder on nine shared MACs, and streams 4 result beats.
module axis_forward
   import axis_forward_pkg::*;
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [63:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic [63:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready
);

   state_t             r_state;
   logic [4:0]         r_in_beat;
   logic [3:0]         r_cyc;
   logic [1:0]         r_out_beat;
   logic               r_s_tready;
   logic               r_m_tvalid;
   logic               r_m_tlast;
   logic [63:0]        r_m_tdata;

   logic signed [15:0] r_param [N_WORDS];
   logic signed [15:0] r_mu1, r_lv1, r_mu2, r_lv2;
   logic signed [15:0] r_y [N_MACS];

   logic               w_s_hs;
   logic [6:0]         w_wr_base;
   logic [6:0]         w_j;
   logic [63:0]        w_next_beat;
   logic [N_MACS-1:0]  w_mac_en;
   logic               w_mac_clr;
   logic signed [15:0] w_mac_a    [N_MACS];
   logic signed [15:0] w_mac_b    [N_MACS];
   logic signed [15:0] w_mac_bias [N_MACS];
   logic signed [15:0] w_mac_q    [N_MACS];
   logic               w_unused_tlast;

   // Framing is by beat count alone; the input tlast carries no meaning here.
   assign w_unused_tlast = s_axis_tlast;

   assign s_axis_tready = r_s_tready;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tlast  = r_m_tlast;
   assign m_axis_tdata  = r_m_tdata;

   assign w_s_hs    = s_axis_tvalid & r_s_tready;
   assign w_wr_base = {r_in_beat, 2'b00};
   assign w_j       = {3'd0, r_cyc};

   // Store the four words of each accepted input beat, word 0 at the lowest address.
   // NOTE: the parameter file is plain storage with no reset; every frame overwrites all of it.
   always_ff @(posedge aclk) begin
      if (w_s_hs) begin
         for (int k = 0; k < 4; k++) begin
            r_param[w_wr_base + 7'(k)] <= s_axis_tdata[16*k +: 16];
         end
      end
   end

   // Route parameter words and latent values to the MACs for the current COMPUTE cycle.
   // NOTE: every output gets a default before the branches so no latch can be inferred.
   always_comb begin
      w_mac_en  = '0;
      w_mac_clr = 1'b0;
      for (int i = 0; i < N_MACS; i++) begin
         w_mac_a[i]    = '0;
         w_mac_b[i]    = '0;
         w_mac_bias[i] = '0;
      end
      if (r_state == ST_COMPUTE) begin
         if (r_cyc <= 4'(CYC_BIAS)) begin
            // Encoder: MAC k handles mu1, lv1, mu2, lv2 for k = 0..3.
            for (int k = 0; k < 4; k++) begin
               w_mac_bias[k] = r_param[7'(OFS_B2 + k)];
               if (r_cyc != 4'(CYC_BIAS)) begin
                  w_mac_en[k] = 1'b1;
                  w_mac_a[k]  = r_param[7'(OFS_X) + w_j];
                  w_mac_b[k]  = r_param[7'(OFS_WC1 + VEC_LEN*k) + w_j];
               end
            end
            w_mac_clr = (r_cyc == 4'd0);
         end else begin
            // Decoder: first cycle multiplies by z1, second adds the z2 term.
            for (int i = 0; i < N_MACS; i++) begin
               w_mac_en[i]   = 1'b1;
               w_mac_a[i]    = r_param[7'(OFS_W + 2*i) + {6'd0, r_cyc[0]}];
               w_mac_b[i]    = (r_cyc == 4'(CYC_DEC1)) ? r_mu1 : r_mu2;
               w_mac_bias[i] = r_param[7'(OFS_B3 + i)];
            end
            w_mac_clr = (r_cyc == 4'(CYC_DEC1));
         end
      end
   end

   for (genvar g = 0; g < N_MACS; g++) begin : g_mac
      q88_mac u_mac (
         .i_clk  (aclk),
         .i_en   (w_mac_en[g]),
         .i_clr  (w_mac_clr),
         .i_a    (w_mac_a[g]),
         .i_b    (w_mac_b[g]),
         .i_bias (w_mac_bias[g]),
         .o_q    (w_mac_q[g])
      );
   end

   // Hold the encoder results once biased and saturated, and the decoder outputs at the end of COMPUTE.
   always_ff @(posedge aclk) begin
      if (r_state == ST_COMPUTE && r_cyc == 4'(CYC_BIAS)) begin
         r_mu1 <= w_mac_q[0];
         r_lv1 <= w_mac_q[1];
         r_mu2 <= w_mac_q[2];
         r_lv2 <= w_mac_q[3];
      end
      if (r_state == ST_COMPUTE && r_cyc == 4'(CYC_DEC2)) begin
         for (int i = 0; i < N_MACS; i++) begin
            r_y[i] <= w_mac_q[i];
         end
      end
   end

   // Select the payload of the beat that follows the one currently presented.
   always_comb begin
      w_next_beat = '0;
      case (r_out_beat)
         2'd0:    w_next_beat = {r_y[7], r_y[6], r_y[5], r_y[4]};
         2'd1:    w_next_beat = {r_lv1, r_mu2, r_mu1, r_y[8]};
         2'd2:    w_next_beat = {48'd0, r_lv2};
         default: w_next_beat = '0;
      endcase
   end

   // Frame controller: counts input beats, sequences COMPUTE and drives the registered output stream.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state    <= ST_LOAD;
         r_in_beat  <= '0;
         r_cyc      <= '0;
         r_out_beat <= '0;
         r_s_tready <= 1'b1;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_m_tdata  <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_s_hs) begin
                  if (r_in_beat == 5'(IN_BEATS-1)) begin
                     r_in_beat  <= '0;
                     r_cyc      <= '0;
                     r_s_tready <= 1'b0;
                     r_state    <= ST_COMPUTE;
                  end else begin
                     r_in_beat <= r_in_beat + 5'd1;
                  end
               end
            end
            ST_COMPUTE: begin
               if (r_cyc == 4'(COMPUTE_CYCLES-1)) begin
                  r_cyc      <= '0;
                  r_out_beat <= '0;
                  r_m_tvalid <= 1'b1;
                  r_m_tlast  <= 1'b0;
                  r_m_tdata  <= {w_mac_q[3], w_mac_q[2], w_mac_q[1], w_mac_q[0]};
                  r_state    <= ST_SEND;
               end else begin
                  r_cyc <= r_cyc + 4'd1;
               end
            end
            ST_SEND: begin
               if (m_axis_tready) begin
                  if (r_out_beat == 2'(OUT_BEATS-1)) begin
                     r_out_beat <= '0;
                     r_m_tvalid <= 1'b0;
                     r_m_tlast  <= 1'b0;
                     r_m_tdata  <= '0;
                     r_s_tready <= 1'b1;
                     r_state    <= ST_LOAD;
                  end else begin
                     r_out_beat <= r_out_beat + 2'd1;
                     r_m_tdata  <= w_next_beat;
                     r_m_tlast  <= (r_out_beat == 2'(OUT_BEATS-2));
                  end
               end
            end
            default: begin
               r_state    <= ST_LOAD;
               r_s_tready <= 1'b1;
               r_m_tvalid <= 1'b0;
               r_m_tlast  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_forward.sv
// Scoreboard bench for axis_forward: directed frames with hand-computed results.
module tb_axis_forward;

   logic        aclk    = 1'b0;
   logic        aresetn = 1'b0;
   logic [63:0] s_axis_tdata  = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tlast  = 1'b0;
   logic        s_axis_tready;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready = 1'b1;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_q [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int unsigned cyc      = 0;
   int unsigned last_tlast_cyc  = 0;
   int unsigned last_accept_cyc = 0;
   int unsigned first_accept_cyc = 0;
   logic [15:0] frame [76];

   // Nominal frame contents.
   logic [15:0] nom_x   [9]  = '{16'h0100,16'h0000,16'h0100,16'h0000,16'h0100,16'h0000,16'h0100,16'h0000,16'h0100};
   logic [15:0] nom_wc1 [9]  = '{16'h0004,16'hffff,16'hfffb,16'h0000,16'hfffb,16'h0003,16'hffad,16'h020d,16'h003f};
   logic [15:0] nom_wd1 [9]  = '{16'h000f,16'hfffa,16'hfffa,16'h0003,16'h0006,16'hfffc,16'hffe9,16'hffee,16'hffa8};
   logic [15:0] nom_wc2 [9]  = '{16'hffff,16'h0009,16'hffff,16'h0009,16'hfff6,16'h0009,16'h0065,16'hffd6,16'h008a};
   logic [15:0] nom_wd2 [9]  = '{16'h000b,16'hfff6,16'h000b,16'hfff7,16'h0015,16'hfff4,16'h00dd,16'h002b,16'h0028};
   logic [15:0] nom_b2  [4]  = '{16'hff23,16'hff16,16'hff20,16'hff60};
   logic [15:0] nom_w   [18] = '{16'h0024,16'h0044,16'h04fb,16'hffe4,16'h0100,16'h0100,16'h0000,16'h0200,
                                 16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,
                                 16'h0000,16'h0000};
   logic [15:0] nom_b3  [9]  = '{16'h04f0,16'hffcc,16'h0000,16'h0010,16'h0005,16'h0006,16'h0007,16'h0008,16'h0009};

   // Nominal results: y1=04ce y2=fafd y3=ff0c y4=0016 y5..y9=5..9, mu1=ff09 lv1=feb6 mu2=0003 lv2=0090.
   localparam logic [63:0] NOM_B0 = {16'h0016, 16'hff0c, 16'hfafd, 16'h04ce};
   localparam logic [63:0] NOM_B1 = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
   localparam logic [63:0] NOM_B2 = {16'hfeb6, 16'h0003, 16'hff09, 16'h0009};
   localparam logic [63:0] NOM_B3 = {48'h0, 16'h0090};

   axis_forward dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Monitor: pops and compares one expected beat per output handshake.
   always @(negedge aclk) begin
      beat_t e;
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", m_axis_tdata, e.data);
            check("beat_last", 64'(m_axis_tlast), 64'(e.last));
         end
         if (m_axis_tlast) last_tlast_cyc = cyc;
      end
   end

   task automatic push_beats(input logic [63:0] b0, input logic [63:0] b1,
                             input logic [63:0] b2, input logic [63:0] b3);
      exp_q.push_back('{data: b0, last: 1'b0});
      exp_q.push_back('{data: b1, last: 1'b0});
      exp_q.push_back('{data: b2, last: 1'b0});
      exp_q.push_back('{data: b3, last: 1'b1});
   endtask

   task automatic build_nominal();
      for (int j = 0; j < 9; j++) begin
         frame[j]      = nom_x[j];
         frame[9 + j]  = nom_wc1[j];
         frame[18 + j] = nom_wd1[j];
         frame[27 + j] = nom_wc2[j];
         frame[36 + j] = nom_wd2[j];
         frame[67 + j] = nom_b3[j];
      end
      for (int j = 0; j < 4; j++)  frame[45 + j] = nom_b2[j];
      for (int j = 0; j < 18; j++) frame[49 + j] = nom_w[j];
   endtask

   // Saturation frame: x = wc1 = 7fff, b21 and wc1 either 7fff or 8000, w11 = 7fff, all else 0.
   task automatic build_sat(input bit neg);
      for (int j = 0; j < 76; j++) frame[j] = 16'h0000;
      for (int j = 0; j < 9; j++) begin
         frame[j]     = 16'h7fff;
         frame[9 + j] = neg ? 16'h8000 : 16'h7fff;
      end
      frame[45] = neg ? 16'h8000 : 16'h7fff;
      frame[49] = 16'h7fff;
   endtask

   task automatic push_sat(input bit neg);
      logic [15:0] s;
      s = neg ? 16'h8000 : 16'h7fff;
      push_beats({48'h0, s}, 64'h0, {16'h0, 16'h0, s, 16'h0}, 64'h0);
   endtask

   task automatic send_beat(input logic [63:0] d, input logic l);
      bit ok = 1'b0;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge aclk);
         ok = s_axis_tready;
         if (ok) last_accept_cyc = cyc;
         @(posedge aclk);
         #1;
      end
      if (!ok) check("s_tready_timeout", 64'(ok), 64'd1);
   endtask

   task automatic send_frame(input int gap_after, input int gap_len);
      for (int b = 0; b < 19; b++) begin
         send_beat({frame[4*b+3], frame[4*b+2], frame[4*b+1], frame[4*b]}, b == 3);
         if (b == 0) first_accept_cyc = last_accept_cyc;
         if (b + 1 == gap_after) begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = 64'hdead_beef_dead_beef;
            repeat (gap_len) @(posedge aclk);
            #1;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   // Called right after the last input beat is accepted.
   task automatic measure_latency();
      int n = 0;
      bit tr_low = 1'b1;
      while (n < 40 && !m_axis_tvalid) begin
         @(posedge aclk);
         #1;
         n++;
         if (s_axis_tready) tr_low = 1'b0;
      end
      check("tvalid_latency", 64'(n), 64'd12);
      check("tready_low_compute", 64'(tr_low), 64'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      bit tr_low = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         if (s_axis_tready) tr_low = 1'b0;
         @(posedge aclk);
         #1;
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      check("tready_low_send", 64'(tr_low), 64'd1);
      @(posedge aclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      bit no_out;

      // Reset state.
      repeat (3) @(posedge aclk);
      #1;
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tlast",  64'(m_axis_tlast),  64'd0);
      check("rst_tdata",  m_axis_tdata,       64'd0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      check("rst_tready", 64'(s_axis_tready), 64'd1);

      // Nominal frame with latency measurement and backpressure on beat1.
      build_nominal();
      push_beats(NOM_B0, NOM_B1, NOM_B2, NOM_B3);
      send_frame(0, 0);
      measure_latency();
      @(posedge aclk);
      #1;
      m_axis_tready = 1'b0;
      repeat (5) begin
         @(posedge aclk);
         #1;
         check("bp_hold_data", m_axis_tdata, NOM_B1);
      end
      check("bp_hold_valid", 64'(m_axis_tvalid), 64'd1);
      check("bp_hold_last",  64'(m_axis_tlast),  64'd0);
      m_axis_tready = 1'b1;
      wait_drain();

      // Input gap of 3 cycles after beat 7.
      build_nominal();
      push_beats(NOM_B0, NOM_B1, NOM_B2, NOM_B3);
      send_frame(7, 3);
      measure_latency();
      wait_drain();

      // Positive and negative saturation.
      build_sat(1'b0);
      push_sat(1'b0);
      send_frame(0, 0);
      wait_drain();
      build_sat(1'b1);
      push_sat(1'b1);
      send_frame(0, 0);
      wait_drain();

      // Reset during COMPUTE aborts the frame.
      build_nominal();
      send_frame(0, 0);
      repeat (5) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      check("abort_tready", 64'(s_axis_tready), 64'd1);
      no_out = 1'b1;
      repeat (30) begin
         @(posedge aclk);
         #1;
         if (m_axis_tvalid) no_out = 1'b0;
      end
      check("abort_no_output", 64'(no_out), 64'd1);

      // Nominal frame after the abort.
      build_nominal();
      push_beats(NOM_B0, NOM_B1, NOM_B2, NOM_B3);
      send_frame(0, 0);
      measure_latency();
      wait_drain();

      // Back-to-back: second frame waits on tready and loads right after beat3.
      build_nominal();
      push_beats(NOM_B0, NOM_B1, NOM_B2, NOM_B3);
      send_frame(0, 0);
      build_sat(1'b0);
      push_sat(1'b0);
      send_frame(0, 0);
      check("b2b_restart_gap", 64'(first_accept_cyc - last_tlast_cyc), 64'd1);
      measure_latency();
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
